rtc_bus_cycle: RTL and testbench



---
 rtl/rtc_bus_pkg.sv | 70 +++++++
 rtl/rtc_bus_cycle_phase_counter.sv | 30 +++
 rtl/rtc_bus_cycle.sv | 133 +++++++++++++
 tb/tb_rtc_bus_cycle.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC multiplexed-bus cycle sequencer.
// Holds the phase encoding, RTC register map and the phase-counter width.
package rtc_bus_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_SU,
    ST_ADDR_PW,
    ST_ADDR_HD,
    ST_GAP,
    ST_DATA_SU,
    ST_DATA_PW,
    ST_DATA_HD,
    ST_FIN
  } state_e;

  localparam logic [7:0] REG_SEG    = 8'h21;
  localparam logic [7:0] REG_MIN    = 8'h22;
  localparam logic [7:0] REG_HORA   = 8'h23;
  localparam logic [7:0] REG_DIA    = 8'h24;
  localparam logic [7:0] REG_MES    = 8'h25;
  localparam logic [7:0] REG_ANO    = 8'h26;
  localparam logic [7:0] REG_SEG_T  = 8'h41;
  localparam logic [7:0] REG_MIN_T  = 8'h42;
  localparam logic [7:0] REG_HORA_T = 8'h43;
  localparam logic [7:0] REG_CMD    = 8'hF0;

  typedef struct packed {
    logic ado;
    logic cso;
    logic rdo;
    logic wro;
    logic oe;
  } pins_t;

  // Pin levels for a phase; reads never drive the bus in the data half.
  function automatic pins_t phase_pins(state_e st, logic wr);
    pins_t p;
    p    = '1;
    p.oe = 1'b0;
    case (st)
      ST_ADDR_SU, ST_ADDR_HD: begin
        p.ado = 1'b0;
        p.cso = 1'b0;
        p.oe  = 1'b1;
      end
      ST_ADDR_PW: begin
        p.ado = 1'b0;
        p.cso = 1'b0;
        p.wro = 1'b0;
        p.oe  = 1'b1;
      end
      ST_DATA_SU, ST_DATA_HD: begin
        p.cso = 1'b0;
        p.oe  = wr;
      end
      ST_DATA_PW: begin
        p.cso = 1'b0;
        p.oe  = wr;
        p.wro = ~wr;
        p.rdo = wr;
      end
      default: ;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/rtc_bus_cycle_phase_counter.sv
// Loadable down-counter timing each bus phase; tc flags the last cycle.
// Saturates at zero so an idle sequencer never sees a stray terminal count.
module rtc_phase_counter
  import rtc_bus_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)               cnt_d = load_val;
    else if (cnt_q != '0)   cnt_d = cnt_q - ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == ONE);

endmodule

// File: rtl/rtc_bus_cycle.sv
// Bus-cycle sequencer for the external RTC multiplexed address/data port.
// One request = address phase, bus-released gap, data phase, done pulse.
module rtc_bus_cycle
  import rtc_bus_pkg::*;
#(
  parameter int unsigned T_SU  = 2,
  parameter int unsigned T_PW  = 4,
  parameter int unsigned T_HD  = 2,
  parameter int unsigned T_GAP = 3
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       req,
  input  logic       wr_nrd,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       ADO,
  output logic       CSO,
  output logic       RDO,
  output logic       WRO,
  inout  wire  [7:0] Bus_Dato_Dir
);

  state_e           state_q, state_d;
  logic             wr_q, wr_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rdata_q, rdata_d;
  logic [7:0]       dout_q, dout_d;
  pins_t            pins_q, pins_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cnt_load, cnt_tc;
  logic [CNT_W-1:0] cnt_val;
  logic             bus_oe;

  rtc_phase_counter u_cnt (
    .clk      (CLK),
    .rst      (Reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .tc       (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: if (req) begin
        state_d = ST_ADDR_SU;
        wr_d    = wr_nrd;
        addr_d  = addr;
        wdata_d = wdata;
      end
      ST_ADDR_SU: if (cnt_tc) state_d = ST_ADDR_PW;
      ST_ADDR_PW: if (cnt_tc) state_d = ST_ADDR_HD;
      ST_ADDR_HD: if (cnt_tc) state_d = ST_GAP;
      ST_GAP:     if (cnt_tc) state_d = ST_DATA_SU;
      ST_DATA_SU: if (cnt_tc) state_d = ST_DATA_PW;
      ST_DATA_PW: if (cnt_tc) begin
        // Sample while RDO is still low on its final cycle.
        if (!wr_q) rdata_d = Bus_Dato_Dir;
        state_d = ST_DATA_HD;
      end
      ST_DATA_HD: if (cnt_tc) state_d = ST_FIN;
      ST_FIN:     if (cnt_tc) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Reload the phase timer on every state change.
  always_comb begin
    cnt_load = (state_d != state_q);
    cnt_val  = '0;
    case (state_d)
      ST_ADDR_SU, ST_DATA_SU: cnt_val = CNT_W'(T_SU);
      ST_ADDR_PW, ST_DATA_PW: cnt_val = CNT_W'(T_PW);
      ST_ADDR_HD, ST_DATA_HD: cnt_val = CNT_W'(T_HD);
      ST_GAP:                 cnt_val = CNT_W'(T_GAP);
      ST_FIN:                 cnt_val = CNT_W'(1);
      default:                cnt_val = '0;
    endcase
  end

  // Pins are registered from the next state so they line up with it.
  always_comb begin
    pins_d = phase_pins(state_d, wr_d);
    dout_d = (state_d inside {ST_ADDR_SU, ST_ADDR_PW, ST_ADDR_HD}) ? addr_d : wdata_d;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      dout_q  <= '0;
      pins_q  <= '{ado: 1'b1, cso: 1'b1, rdo: 1'b1, wro: 1'b1, oe: 1'b0};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      dout_q  <= dout_d;
      pins_q  <= pins_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus_oe       = pins_q.oe;
  assign Bus_Dato_Dir = bus_oe ? dout_q : 8'bz;
  assign ADO          = pins_q.ado;
  assign CSO          = pins_q.cso;
  assign RDO          = pins_q.rdo;
  assign WRO          = pins_q.wro;
  assign busy         = busy_q;
  assign done         = done_q;
  assign rdata        = rdata_q;

endmodule

// File: tb/tb_rtc_bus_cycle.sv
// Self-checking bench for rtc_bus_cycle: a cycle-offset reference model checks
// every cycle while table vectors, corner sequences and random traffic run.
module tb_rtc_bus_cycle;
  import rtc_bus_pkg::*;

  localparam int SU = 2, PW = 4, HD = 2, GAP = 3;
  localparam int LEN  = 2 * (SU + PW + HD) + GAP + 1;
  localparam int LEN2 = 2 * (1 + 1 + 1) + 1 + 1;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       Reset, req, wr_nrd;
  logic [7:0] addr, wdata, rd_val;
  logic       busy, done, ADO, CSO, RDO, WRO;
  logic [7:0] rdata;
  wire  [7:0] bus;
  assign bus = (RDO == 1'b0) ? rd_val : 8'bz;

  logic       req2;
  logic [7:0] addr2, wdata2;
  logic       busy2, done2, ADO2, CSO2, RDO2, WRO2;
  logic [7:0] rdata2;
  wire  [7:0] bus2;

  rtc_bus_cycle dut (
    .CLK(CLK), .Reset(Reset), .req(req), .wr_nrd(wr_nrd), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .ADO(ADO), .CSO(CSO), .RDO(RDO), .WRO(WRO),
    .Bus_Dato_Dir(bus)
  );

  rtc_bus_cycle #(.T_SU(1), .T_PW(1), .T_HD(1), .T_GAP(1)) dut_min (
    .CLK(CLK), .Reset(Reset), .req(req2), .wr_nrd(1'b1), .addr(addr2), .wdata(wdata2),
    .busy(busy2), .done(done2), .rdata(rdata2), .ADO(ADO2), .CSO(CSO2), .RDO(RDO2), .WRO(WRO2),
    .Bus_Dato_Dir(bus2)
  );

  typedef struct packed {
    logic       ado, cso, rdo, wro, oe;
    logic [7:0] dout;
    logic       busy, done;
  } exp_t;

  typedef struct {
    logic       wr;
    logic [7:0] addr, wdata, rdv, exp_rdata;
    int         exp_lat;
  } vec_t;

  int cyc, n_tests, n_fail, overlap_cnt;
  int done_q[$];
  int done2_cnt, done2_cyc, wro2_low, wro2_runs;
  logic wro2_prev;
  logic saw33;

  // Reference model state: k = cycles since accept, 0 = idle.
  int mk, nk;
  logic mwr;
  logic [7:0] maddr, mwdata, mrdata, naddr, nwdata;

  function automatic exp_t ref_out(int k, logic wr, logic [7:0] a, logic [7:0] w,
                                   int su, int pw, int hd, int gap);
    exp_t e;
    int a1, a2, a3, g, d1, d2, d3;
    logic strobe;
    a1 = su; a2 = a1 + pw; a3 = a2 + hd; g = a3 + gap;
    d1 = g + su; d2 = d1 + pw; d3 = d2 + hd;
    e.ado = 1'b1; e.cso = 1'b1; e.rdo = 1'b1; e.wro = 1'b1; e.oe = 1'b0;
    e.dout = 8'h00; e.busy = (k != 0); e.done = 1'b0;
    if (k >= 1 && k <= a3) begin
      e.cso = 1'b0; e.ado = 1'b0; e.oe = 1'b1; e.dout = a;
      e.wro = !(k > a1 && k <= a2);
    end else if (k > g && k <= d3) begin
      e.cso = 1'b0;
      strobe = (k > d1 && k <= d2);
      if (wr) begin e.oe = 1'b1; e.dout = w; e.wro = !strobe; end
      else    e.rdo = !strobe;
    end else if (k == d3 + 1) begin
      e.done = 1'b1;
    end
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic cmp(string p, exp_t a, exp_t e, logic [7:0] rd_a, logic [7:0] rd_e);
    chk({p, "ADO"}, 32'(a.ado), 32'(e.ado));
    chk({p, "CSO"}, 32'(a.cso), 32'(e.cso));
    chk({p, "RDO"}, 32'(a.rdo), 32'(e.rdo));
    chk({p, "WRO"}, 32'(a.wro), 32'(e.wro));
    chk({p, "bus_oe"}, 32'(a.oe), 32'(e.oe));
    if (e.oe) chk({p, "bus"}, 32'(a.dout), 32'(e.dout));
    chk({p, "busy"}, 32'(a.busy), 32'(e.busy));
    chk({p, "done"}, 32'(a.done), 32'(e.done));
    chk({p, "rdata"}, 32'(rd_a), 32'(rd_e));
  endtask

  task automatic tick();
    exp_t a;
    @(posedge CLK);
    cyc++;
    if (Reset) begin
      mk = 0; mrdata = 8'h00; nk = 0;
    end else begin
      if (mk == 0) begin
        if (req) begin mk = 1; mwr = wr_nrd; maddr = addr; mwdata = wdata; end
      end else begin
        if (!mwr && mk == 2 * SU + PW + HD + GAP + PW) mrdata = rd_val;
        mk = (mk == LEN) ? 0 : mk + 1;
      end
      if (nk == 0) begin
        if (req2) begin nk = 1; naddr = addr2; nwdata = wdata2; end
      end else begin
        nk = (nk == LEN2) ? 0 : nk + 1;
      end
    end
    @(negedge CLK);
    a = '{ado: ADO, cso: CSO, rdo: RDO, wro: WRO, oe: dut.bus_oe, dout: bus, busy: busy, done: done};
    cmp("", a, ref_out(mk, mwr, maddr, mwdata, SU, PW, HD, GAP), rdata, mrdata);
    a = '{ado: ADO2, cso: CSO2, rdo: RDO2, wro: WRO2, oe: dut_min.bus_oe, dout: bus2,
          busy: busy2, done: done2};
    cmp("min_", a, ref_out(nk, 1'b1, naddr, nwdata, 1, 1, 1, 1), rdata2, 8'h00);
    if (!RDO && !WRO) overlap_cnt++;
    if (dut.bus_oe && bus == 8'h33) saw33 = 1'b1;
    if (done) done_q.push_back(cyc);
    if (done2) begin done2_cnt++; done2_cyc = cyc; end
    if (!WRO2) wro2_low++;
    if (!WRO2 && wro2_prev) wro2_runs++;
    wro2_prev = WRO2;
  endtask

  task automatic wait_done(input bit min_dut, input int c0, output int lat);
    int d0;
    d0 = min_dut ? done2_cnt : done_q.size();
    lat = -1;
    for (int j = 0; j < 64; j++) begin
      tick();
      if (!min_dut && done_q.size() != d0) begin lat = done_q[$] - c0; break; end
      if (min_dut && done2_cnt != d0)      begin lat = done2_cyc - c0; break; end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    int c0, lat, idx, d0;
    cyc = 0; n_tests = 0; n_fail = 0; overlap_cnt = 0;
    done2_cnt = 0; done2_cyc = 0; wro2_low = 0; wro2_runs = 0; wro2_prev = 1'b1;
    saw33 = 1'b0;
    mk = 0; nk = 0; mwr = 1'b0; maddr = 0; mwdata = 0; mrdata = 0; naddr = 0; nwdata = 0;
    Reset = 1'b1; req = 1'b0; wr_nrd = 1'b0; addr = 0; wdata = 0; rd_val = 0;
    req2 = 1'b0; addr2 = 0; wdata2 = 0;

    tbl[0] = '{1'b1, REG_SEG,    8'h45, 8'h00, 8'h00, 20};
    tbl[1] = '{1'b0, REG_DIA,    8'h00, 8'h15, 8'h15, 20};
    tbl[2] = '{1'b1, REG_MES,    8'h99, 8'hEE, 8'h15, 20};
    tbl[3] = '{1'b0, REG_CMD,    8'h00, 8'hA5, 8'hA5, 20};
    tbl[4] = '{1'b0, REG_HORA_T, 8'h00, 8'h00, 8'h00, 20};
    tbl[5] = '{1'b0, REG_ANO,    8'h00, 8'h3C, 8'h3C, 20};

    tick(); tick();
    chk("rst_strobes", 32'({ADO, CSO, RDO, WRO}), 32'hF);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rdata", 32'(rdata), 0);
    Reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      wr_nrd = tbl[i].wr; addr = tbl[i].addr; wdata = tbl[i].wdata; rd_val = tbl[i].rdv;
      req = 1'b1; c0 = cyc;
      tick();
      req = 1'b0;
      wait_done(1'b0, c0, lat);
      chk("tbl_done_lat", 32'(lat), 32'(tbl[i].exp_lat));
      tick();
      chk("tbl_rdata", 32'(rdata), 32'(tbl[i].exp_rdata));
      chk("tbl_idle_busy", 32'(busy), 0);
    end

    // Second req during an access must be dropped.
    idx = done_q.size(); saw33 = 1'b0;
    wr_nrd = 1'b1; addr = 8'h21; wdata = 8'h45; req = 1'b1; c0 = cyc;
    tick(); req = 1'b0;
    repeat (7) tick();
    req = 1'b1; addr = 8'h33;
    tick(); req = 1'b0; addr = 8'h21;
    repeat (12) tick();
    chk("rej_done_cnt", 32'(done_q.size() - idx), 1);
    if (done_q.size() > idx) chk("rej_done_cyc", 32'(done_q[idx] - c0), 20);
    chk("rej_busy21", 32'(busy), 0);
    chk("rej_no_33", 32'(saw33), 0);

    // Make rdata nonzero, then abort a write at cycle 10.
    wr_nrd = 1'b0; addr = REG_SEG; rd_val = 8'h77; req = 1'b1; c0 = cyc;
    tick(); req = 1'b0;
    wait_done(1'b0, c0, lat);
    tick();
    chk("pre_rst_rdata", 32'(rdata), 32'h77);
    idx = done_q.size();
    wr_nrd = 1'b1; addr = REG_MIN; wdata = 8'h59; req = 1'b1; c0 = cyc;
    tick(); req = 1'b0;
    repeat (9) tick();
    Reset = 1'b1;
    tick();
    chk("abort_strobes", 32'({ADO, CSO, RDO, WRO}), 32'hF);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_rdata", 32'(rdata), 0);
    chk("abort_oe", 32'(dut.bus_oe), 0);
    Reset = 1'b0;
    repeat (15) tick();
    chk("abort_no_done", 32'(done_q.size() - idx), 0);
    wr_nrd = 1'b1; addr = REG_HORA; wdata = 8'h12; req = 1'b1; c0 = cyc;
    tick(); req = 1'b0;
    wait_done(1'b0, c0, lat);
    chk("post_rst_lat", 32'(lat), 20);
    tick();

    // req held high: write 0x10 to 0x22, then read it back.
    idx = done_q.size();
    wr_nrd = 1'b1; addr = REG_MIN; wdata = 8'h10; rd_val = 8'h10; req = 1'b1; c0 = cyc;
    tick();
    wr_nrd = 1'b0;
    repeat (20) tick();
    chk("b2b_idle21", 32'(busy), 0);
    tick();
    chk("b2b_start22", 32'({busy, ADO, CSO}), 32'b100);
    repeat (19) tick();
    req = 1'b0;
    tick(); tick();
    chk("b2b_done_cnt", 32'(done_q.size() - idx), 2);
    if (done_q.size() >= idx + 2) begin
      chk("b2b_first_done", 32'(done_q[idx] - c0), 20);
      chk("b2b_done_gap", 32'(done_q[idx+1] - done_q[idx]), 21);
    end
    chk("b2b_rdata", 32'(rdata), 32'h10);

    // Minimum timing instance.
    wro2_low = 0; wro2_runs = 0;
    req2 = 1'b1; addr2 = REG_SEG_T; wdata2 = 8'h5A; c0 = cyc;
    tick(); req2 = 1'b0;
    wait_done(1'b1, c0, lat);
    chk("min_done_lat", 32'(lat), 8);
    chk("min_wro_low", 32'(wro2_low), 2);
    chk("min_wro_runs", 32'(wro2_runs), 2);
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      Reset  = ($urandom_range(0, 99) == 0);
      req    = ($urandom_range(0, 2) == 0);
      wr_nrd = 1'($urandom);
      addr   = 8'($urandom);
      wdata  = 8'($urandom);
      rd_val = 8'($urandom);
      req2   = ($urandom_range(0, 3) == 0);
      addr2  = 8'($urandom);
      wdata2 = 8'($urandom);
      tick();
    end
    Reset = 1'b0; req = 1'b0; req2 = 1'b0;
    repeat (25) tick();

    chk("no_rd_wr_overlap", 32'(overlap_cnt), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
